// File: rtl/mem_arbiter.sv
// Shares one AXI4-Lite master between the fetch (read-only) and data (read/write) native ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_done,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_done,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready
);

    typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

    state_t state;
    logic   owner_i;
    logic   aw_ok, w_ok;
    logic   d_elig, i_elig, grant_d, grant_i;
    logic   aw_hs, w_hs;
    logic   unused_resp;

    // Error responses complete a transaction like OKAY does.
    assign unused_resp = ^{axi_rresp, axi_bresp};

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;

`ifdef MEM_ARB_RR_EN
    logic last_win;  // 0 = data won the previous grant

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_win <= 1'b0;
        else if (state == IDLE && (grant_d || grant_i))
            last_win <= grant_i;
    end
`endif

    // A port whose done is high is still holding req for the finished transfer.
    always_comb begin
        d_elig  = d_req && !d_done;
        i_elig  = i_req && !i_done;
        grant_d = 1'b0;
        grant_i = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (d_elig && i_elig) begin
            grant_i = (last_win == 1'b0);
            grant_d = !grant_i;
        end else begin
            grant_d = d_elig;
            grant_i = i_elig;
        end
`else
        grant_d = d_elig;
        grant_i = i_elig && !d_elig;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            owner_i     <= 1'b0;
            aw_ok       <= 1'b0;
            w_ok        <= 1'b0;
            i_rdata     <= '0;
            i_done      <= 1'b0;
            d_rdata     <= '0;
            d_done      <= 1'b0;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_i <= 1'b0;
                        if (d_we) begin
                            axi_awaddr  <= d_addr;
                            axi_wdata   <= d_wdata;
                            axi_wstrb   <= d_wstrb;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            state       <= W;
                        end else begin
                            axi_araddr  <= d_addr;
                            axi_arvalid <= 1'b1;
                            state       <= AR;
                        end
                    end else if (grant_i) begin
                        owner_i     <= 1'b1;
                        axi_araddr  <= i_addr;
                        axi_arvalid <= 1'b1;
                        state       <= AR;
                    end
                end
                AR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= R;
                    end
                end
                R: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        if (owner_i) begin
                            i_rdata <= axi_rdata;
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= axi_rdata;
                            d_done  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                W: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        aw_ok       <= 1'b1;
                    end
                    if (w_hs) begin
                        axi_wvalid <= 1'b0;
                        w_ok       <= 1'b1;
                    end
                    // Clear comes last so it overrides a same-cycle flag set.
                    if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                        aw_ok      <= 1'b0;
                        w_ok       <= 1'b0;
                        axi_bready <= 1'b1;
                        state      <= B;
                    end
                end
                B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (owner_i)
                            i_done <= 1'b1;
                        else
                            d_done <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
